// File: rtl/chroma_quad_demod.sv
// Quadrature demodulator for the composite chroma path.
// Aligns the sample stream to the cordic rotator output, mixes it with
// cos/sin, and integrates-and-dumps over 2^AVG_LOG2 valid samples to give
// one decimated, clamped I/Q pair per block.
module chroma_quad_demod #(
    parameter int DATA_WIDTH = 12,
    parameter int STAGES     = 12,
    parameter int FRAC_BITS  = 10,
    parameter int AVG_LOG2   = 4,
    parameter int OUT_WIDTH  = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_valid,
    input  logic                         sample_first,
    input  logic signed [DATA_WIDTH-1:0] sin_in,
    input  logic signed [DATA_WIDTH-1:0] cos_in,
    output logic signed [OUT_WIDTH-1:0]  out_i,
    output logic signed [OUT_WIDTH-1:0]  out_q,
    output logic                         out_valid,
    output logic                         out_sat
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = PW + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int SH = AVG_LOG2 + FRAC_BITS;
    localparam logic [CW-1:0] BLOCK_N = CW'(1 << AVG_LOG2);

    localparam logic signed [AW-1:0] SUM_MAX = {{(AW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SUM_MIN = {{(AW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // delay line
    logic signed [DATA_WIDTH-1:0] dl_s [STAGES];
    logic [STAGES-1:0]            dl_v;
    logic [STAGES-1:0]            dl_f;

    // mixer stage
    logic                 m_v, m_f;
    logic signed [PW-1:0] m_pi, m_pq;
    logic signed [PW-1:0] prod_i, prod_q;

    // accumulate stage
    logic signed [AW-1:0] acc_i, acc_q;
    logic [CW-1:0]        count;
    logic signed [AW-1:0] ext_i, ext_q, tot_i, tot_q;
    logic [CW-1:0]        cnt_next;
    logic                 d_v;
    logic signed [AW-1:0] d_sum_i, d_sum_q;

    // output stage
    logic signed [AW-1:0]        sh_i, sh_q;
    logic                        sat_i, sat_q;
    logic signed [OUT_WIDTH-1:0] cl_i, cl_q;

    // Delay valid/first flags by the rotator latency; cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_v <= '0;
            dl_f <= '0;
        end else begin
            dl_v[0] <= sample_valid;
            dl_f[0] <= sample_first;
            for (int unsigned i = 1; i < STAGES; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_f[i] <= dl_f[i-1];
            end
        end
    end

    // Delay sample data alongside the flags (no reset needed on data).
    always_ff @(posedge clk) begin
        dl_s[0] <= sample_in;
        for (int unsigned i = 1; i < STAGES; i++) begin
            dl_s[i] <= dl_s[i-1];
        end
    end

    // Full-precision products of the aligned sample with cos/sin.
    always_comb begin
        prod_i = PW'(dl_s[STAGES-1]) * PW'(cos_in);
        prod_q = PW'(dl_s[STAGES-1]) * PW'(sin_in);
    end

    // Mixer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_v  <= 1'b0;
            m_f  <= 1'b0;
            m_pi <= '0;
            m_pq <= '0;
        end else begin
            m_v  <= dl_v[STAGES-1];
            m_f  <= dl_f[STAGES-1];
            m_pi <= prod_i;
            m_pq <= prod_q;
        end
    end

    // Next accumulator value: a first-flagged product restarts the block.
    always_comb begin
        ext_i    = AW'(m_pi);
        ext_q    = AW'(m_pq);
        tot_i    = (m_f ? '0 : acc_i) + ext_i;
        tot_q    = (m_f ? '0 : acc_q) + ext_q;
        cnt_next = m_f ? CW'(1) : count + CW'(1);
    end

    // Integrate valid products; hand the block sum to the output stage on the Nth.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i   <= '0;
            acc_q   <= '0;
            count   <= '0;
            d_v     <= 1'b0;
            d_sum_i <= '0;
            d_sum_q <= '0;
        end else begin
            d_v <= 1'b0;
            if (m_v) begin
                if (cnt_next == BLOCK_N) begin
                    d_v     <= 1'b1;
                    d_sum_i <= tot_i;
                    d_sum_q <= tot_q;
                    acc_i   <= '0;
                    acc_q   <= '0;
                    count   <= '0;
                end else begin
                    acc_i <= tot_i;
                    acc_q <= tot_q;
                    count <= cnt_next;
                end
            end
        end
    end

    // Scale the block sum (floor shift) and clamp to the output range.
    always_comb begin
        sh_i  = d_sum_i >>> SH;
        sh_q  = d_sum_q >>> SH;
        sat_i = (sh_i > SUM_MAX) || (sh_i < SUM_MIN);
        sat_q = (sh_q > SUM_MAX) || (sh_q < SUM_MIN);
        cl_i  = sat_i ? (sh_i[AW-1] ? OUT_MIN : OUT_MAX) : sh_i[OUT_WIDTH-1:0];
        cl_q  = sat_q ? (sh_q[AW-1] ? OUT_MIN : OUT_MAX) : sh_q[OUT_WIDTH-1:0];
    end

    // Output register: values hold between one-cycle valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= d_v;
            if (d_v) begin
                out_i   <= cl_i;
                out_q   <= cl_q;
                out_sat <= sat_i | sat_q;
            end
        end
    end

endmodule

// File: tb/tb_chroma_quad_demod.sv
// Scoreboard bench for chroma_quad_demod: directed blocks push expected
// I/Q/sat/edge records; a negedge monitor pops and compares on out_valid.
module tb_chroma_quad_demod;

    localparam int DW = 12;
    localparam int S  = 12;
    localparam int OW = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] sample_in = '0;
    logic                 sample_valid = 1'b0;
    logic                 sample_first = 1'b0;
    logic signed [DW-1:0] sin_in = '0;
    logic signed [DW-1:0] cos_in = '0;
    logic signed [OW-1:0] out_i, out_q;
    logic                 out_valid, out_sat;

    chroma_quad_demod #(
        .DATA_WIDTH(DW),
        .STAGES(S),
        .FRAC_BITS(10),
        .AVG_LOG2(4),
        .OUT_WIDTH(OW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_first(sample_first),
        .sin_in(sin_in),
        .cos_in(cos_in),
        .out_i(out_i),
        .out_q(out_q),
        .out_valid(out_valid),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int i;
        int q;
        int sat;
        int at;
    } exp_t;
    exp_t sbq[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare every output pulse against the scoreboard head.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_i", int'(out_i), e.i);
                chk("out_q", int'(out_q), e.q);
                chk("out_sat", int'(out_sat), e.sat);
                if (e.at >= 0) chk("out_edge", cyc - 1, e.at);
            end
        end
    end

    // Drive one cycle; e returns the index of the edge that sampled it.
    task automatic step(input logic v, input logic f, input int s, output int e);
        sample_valid = v;
        sample_first = f;
        sample_in    = DW'(s);
        @(posedge clk);
        e = cyc;
        #1;
    endtask

    task automatic idle(input int n);
        int e;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, e);
    endtask

    task automatic push(input int i, input int q, input int sat, input int at);
        exp_t x;
        x.i = i; x.q = q; x.sat = sat; x.at = at;
        sbq.push_back(x);
    endtask

    // 16 valid samples, first flag on the first; expected result pushed.
    task automatic block16(input int s, input int ei, input int eq, input int esat);
        int e;
        for (int k = 0; k < 16; k++) step(1'b1, k == 0, s, e);
        push(ei, eq, esat, e + S + 2);
    endtask

    initial begin
        int e;
        int e0;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_i", int'(out_i), 0);
        chk("rst_out_q", int'(out_q), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        rst = 1'b0;
        idle(2);

        // unity cosine, latency from first sample
        cos_in = 12'sd1024; sin_in = 12'sd0;
        idle(2);
        step(1'b1, 1'b1, 1000, e0);
        for (int k = 1; k < 16; k++) step(1'b1, 1'b0, 1000, e);
        push(1000, 0, 0, e0 + 15 + S + 2);
        idle(25);

        // 45 degrees, two back-to-back free-running blocks
        cos_in = 12'sd724; sin_in = 12'sd724;
        idle(2);
        for (int k = 0; k < 32; k++) begin
            step(1'b1, k == 0, 1000, e);
            if (k == 15 || k == 31) push(707, 707, 0, e + S + 2);
        end
        idle(25);

        // saturation high then low
        cos_in = 12'sd2047; sin_in = 12'sd0;
        idle(2);
        block16(2047, 2047, 0, 1);
        idle(25);
        block16(-2048, -2048, 0, 1);
        idle(25);

        // mid-block reset clears outputs and discards the partial block
        cos_in = 12'sd1024; sin_in = 12'sd0;
        idle(2);
        for (int k = 0; k < 8; k++) step(1'b1, k == 0, 300, e);
        rst = 1'b1;
        step(1'b0, 1'b0, 0, e);
        chk("midrst_out_i", int'(out_i), 0);
        chk("midrst_out_q", int'(out_q), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_sat", int'(out_sat), 0);
        rst = 1'b0;
        idle(2);
        block16(300, 300, 0, 0);
        idle(25);

        // alternating valid: only valid cycles advance the count
        for (int k = 0; k < 32; k++) begin
            step(k % 2 == 0, k == 0, 500, e);
            if (k == 30) push(500, 0, 0, e + S + 2);
        end
        idle(25);

        // partial block of 5 discarded by a new first flag
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, 2000, e);
        block16(100, 100, 0, 0);
        idle(25);

        // drain
        for (int k = 0; k < 100 && sbq.size() != 0; k++) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
